// File: rtl/uart_rx8.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle valid / frame_err pulses.
module uart_rx8 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx8.sv
// Directed bench for uart_rx8 at CLKS_PER_BIT=16 (clock period 20 time units).
module tb_uart_rx8;

    localparam int unsigned CPB = 16;
    localparam int unsigned TCK = 20;
    localparam int unsigned BIT = CPB * TCK;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_rx8 #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    // Monitor samples 1 unit after each rising edge.
    int         cyc = 0;
    int         vcount = 0;
    int         fecount = 0;
    int         both_high = 0;
    int         busy_cnt = 0;
    int         last_valid_cyc = 0;
    int         busy_fall_cyc = 0;
    logic       prev_busy = 1'b0;
    logic       busy_at_valid = 1'b1;
    logic       prev_busy_at_valid = 1'b0;
    logic [7:0] rxq[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (valid) begin
            vcount++;
            rxq.push_back(data);
            last_valid_cyc     = cyc;
            busy_at_valid      = busy;
            prev_busy_at_valid = prev_busy;
        end
        if (frame_err) fecount++;
        if (valid && frame_err) both_high++;
        if (busy) busy_cnt++;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves rx at the stop value once the stop bit period has elapsed.
    task automatic send_frame(input logic [7:0] b, input int unsigned per, input logic stop);
        rx = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(per);
        end
        rx = stop;
        #(per);
    endtask

    int base;
    int fall_cyc;
    int lat;
    int rise_cyc;

    initial begin
        idle(4);
        #1;
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Single frame 0xA5 with latency measurement
        fall_cyc = cyc;
        send_frame(8'hA5, BIT, 1'b1);
        idle(20);
        lat = last_valid_cyc - fall_cyc;
        check("a5_count", vcount, 1);
        check("a5_data", {24'd0, rxq[0]}, 32'hA5);
        check("a5_latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
        check("a5_no_ferr", fecount, 0);
        check("a5_busy_low_at_valid", {31'd0, busy_at_valid}, 32'd0);
        check("a5_busy_high_before", {31'd0, prev_busy_at_valid}, 32'd1);

        // Back-to-back frames, no idle gap
        base = vcount;
        send_frame(8'h00, BIT, 1'b1);
        send_frame(8'hFF, BIT, 1'b1);
        send_frame(8'h3C, BIT, 1'b1);
        idle(20);
        check("b2b_count", vcount - base, 3);
        check("b2b_d0", {24'd0, rxq[base]}, 32'h00);
        check("b2b_d1", {24'd0, rxq[base+1]}, 32'hFF);
        check("b2b_d2", {24'd0, rxq[base+2]}, 32'h3C);

        // Glitch of 4 cycles on the line
        base = vcount;
        busy_cnt = 0;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_no_valid", vcount - base, 0);
        check("glitch_no_ferr", fecount, 0);
        check("glitch_busy_len", {31'd0, (busy_cnt >= 6 && busy_cnt <= 11)}, 32'd1);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);

        // Stop bit low then line held low (break)
        base = vcount;
        send_frame(8'h55, BIT, 1'b0);
        idle(100);
        check("brk_busy_held", {31'd0, busy}, 32'd1);
        rise_cyc = cyc;
        rx = 1'b1;
        idle(20);
        check("brk_ferr_once", fecount, 1);
        check("brk_no_valid", vcount - base, 0);
        check("brk_data_kept", {24'd0, data}, 32'h3C);
        check("brk_busy_fall", busy_fall_cyc - rise_cyc, 3);
        send_frame(8'h12, BIT, 1'b1);
        idle(20);
        check("after_brk_count", vcount - base, 1);
        check("after_brk_data", {24'd0, rxq[base]}, 32'h12);

        // Reset during bit 4 of frame 0xF0 (remaining bits are all 1)
        base = vcount;
        fork
            send_frame(8'hF0, BIT, 1'b1);
            begin
                #(88 * TCK);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("abort_data", {24'd0, data}, 32'h00);
                check("abort_valid", {31'd0, valid}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(40);
        check("abort_no_valid", vcount - base, 0);
        check("abort_no_ferr", fecount, 1);
        send_frame(8'h81, BIT, 1'b1);
        idle(20);
        check("abort_next_count", vcount - base, 1);
        check("abort_next_data", {24'd0, rxq[base]}, 32'h81);

        // Bit-rate tolerance at +/-3%
        base = vcount;
        send_frame(8'hC3, BIT - TCK / 2, 1'b1);
        idle(40);
        send_frame(8'hC3, BIT + TCK / 2, 1'b1);
        idle(40);
        check("rate_3pct_count", vcount - base, 2);
        check("rate_m3pct_data", {24'd0, rxq[base]}, 32'hC3);
        check("rate_p3pct_data", {24'd0, rxq[base+1]}, 32'hC3);
        check("rate_ferr", fecount, 1);
        check("never_both_high", both_high, 0);

        // +/-6% is informational only
        for (int p = 15; p <= 17; p += 2) begin
            base = vcount;
            send_frame(8'hC3, p * TCK, 1'b1);
            idle(200);
            if (vcount > base)
                $display("info: period %0d cycles -> byte 0x%0h", p, rxq[base]);
            else
                $display("info: period %0d cycles -> no byte", p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
